sobel_frame_sequencer: RTL and testbench

//   Frame-level scheduler for the 3x3 Sobel window controller. Reads a WxH grayscale

---
 rtl/sobel_frame_sequencer.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sobel_frame_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_frame_sequencer
//  Purpose  : Frame-level scheduler for a 3x3 Sobel window controller. It walks
//             a WxH grayscale frame held in a 1-cycle-latency pixel RAM in
//             vertical 3-column strips. For each strip it restarts the window
//             controller, feeds the pixels in, and writes the controller's
//             (H-2) results to a result RAM. After the last strip it pulses
//             done.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk_i          clock
//    nreset_i       asynchronous active-low reset
//    cfg_width_i    frame width W, sampled on an accepted start_i
//    cfg_height_i   frame height H, sampled on an accepted start_i
//    start_i        one-cycle frame request (ignored while busy_o)
//    busy_o         high from the accepted start through the done_o cycle
//    done_o         one-cycle pulse after the last result is written
//    err_cfg_o      one-cycle pulse when a start with W<3 or H<3 is rejected
//    rd_en_o        pixel RAM read strobe
//    rd_addr_o      pixel RAM address, row*W + col
//    rd_data_i      pixel RAM data, valid the cycle after rd_en_o
//    start_sobel_o  window-controller enable (low restarts its window fill)
//    px_rdy_o       pixel strobe to the window controller
//    px_o           pixel to the window controller
//    sobel_rdy_i    result strobe from the window controller
//    sobel_px_i     result pixel from the window controller
//    wr_en_o        result RAM write strobe
//    wr_addr_o      result RAM address, y*(W-2) + x
//    wr_data_o      result pixel
// ============================================================================
module sobel_frame_sequencer #(
    parameter int PIXEL_WIDTH = 8,
    parameter int DIM_BITS    = 8,
    parameter int ADDR_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   nreset_i,
    input  logic [DIM_BITS-1:0]    cfg_width_i,
    input  logic [DIM_BITS-1:0]    cfg_height_i,
    input  logic                   start_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   err_cfg_o,
    output logic                   rd_en_o,
    output logic [ADDR_WIDTH-1:0]  rd_addr_o,
    input  logic [PIXEL_WIDTH-1:0] rd_data_i,
    output logic                   start_sobel_o,
    output logic                   px_rdy_o,
    output logic [PIXEL_WIDTH-1:0] px_o,
    input  logic                   sobel_rdy_i,
    input  logic [PIXEL_WIDTH-1:0] sobel_px_i,
    output logic                   wr_en_o,
    output logic [ADDR_WIDTH-1:0]  wr_addr_o,
    output logic [PIXEL_WIDTH-1:0] wr_data_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FIRST = 3'd1,
        S_NEXT  = 3'd2,
        S_DRAIN = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam logic [DIM_BITS-1:0] C_ONE   = DIM_BITS'(1);
    localparam logic [DIM_BITS-1:0] C_TWO   = DIM_BITS'(2);
    localparam logic [DIM_BITS-1:0] C_THREE = DIM_BITS'(3);

    state_t                   state_q, state_d;
    logic [DIM_BITS-1:0]      width_q, width_d;
    logic [DIM_BITS-1:0]      height_q, height_d;
    logic [DIM_BITS-1:0]      strip_x_q, strip_x_d;
    logic [DIM_BITS-1:0]      row_q, row_d;
    logic [1:0]               col_q, col_d;
    logic [ADDR_WIDTH-1:0]    row_base_q, row_base_d;   // row_q * W
    logic [DIM_BITS-1:0]      res_y_q, res_y_d;
    logic [ADDR_WIDTH-1:0]    res_base_q, res_base_d;   // res_y_q * (W-2)
    logic                     gap_q, gap_d;
    logic                     err_q, err_d;
    logic                     px_rdy_q, px_rdy_d;
    logic [PIXEL_WIDTH-1:0]   px_hold_q, px_hold_d;
    logic                     wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]    wr_addr_q, wr_addr_d;
    logic [PIXEL_WIDTH-1:0]   wr_data_q, wr_data_d;

    logic                     rd_en;
    logic                     sobel_en;
    logic                     done;
    logic                     res_accept;
    logic [DIM_BITS-1:0]      res_target;
    logic [DIM_BITS-1:0]      width_m2;
    logic [ADDR_WIDTH-1:0]    strip_x_ext;
    logic [ADDR_WIDTH-1:0]    width_ext;
    logic [ADDR_WIDTH-1:0]    width_m2_ext;
    logic [ADDR_WIDTH-1:0]    col_ext;

    assign res_target   = height_q - C_TWO;
    assign width_m2     = width_q - C_TWO;
    assign strip_x_ext  = {{(ADDR_WIDTH-DIM_BITS){1'b0}}, strip_x_q};
    assign width_ext    = {{(ADDR_WIDTH-DIM_BITS){1'b0}}, width_q};
    assign width_m2_ext = {{(ADDR_WIDTH-DIM_BITS){1'b0}}, width_m2};
    assign col_ext      = {{(ADDR_WIDTH-2){1'b0}}, col_q};

    // Results are only taken while a strip is active, and never beyond the
    // H-2 the strip can produce, so a stray strobe cannot write past the strip.
    assign res_accept = sobel_rdy_i
                      && ((state_q == S_FIRST) || (state_q == S_NEXT) || (state_q == S_DRAIN))
                      && (res_y_q != res_target);

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        height_d   = height_q;
        strip_x_d  = strip_x_q;
        row_d      = row_q;
        col_d      = col_q;
        row_base_d = row_base_q;
        res_y_d    = res_y_q;
        res_base_d = res_base_q;
        gap_d      = gap_q;
        err_d      = 1'b0;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_en      = 1'b0;
        sobel_en   = 1'b0;
        done       = 1'b0;

        // Result path: the write address is frozen at capture time, so a strip
        // advance on the following cycle cannot disturb it.
        if (res_accept) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = res_base_q + strip_x_ext;
            wr_data_d  = sobel_px_i;
            res_y_d    = res_y_q + C_ONE;
            res_base_d = res_base_q + width_m2_ext;
        end

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if ((cfg_width_i < C_THREE) || (cfg_height_i < C_THREE)) begin
                        err_d = 1'b1;
                    end else begin
                        width_d    = cfg_width_i;
                        height_d   = cfg_height_i;
                        strip_x_d  = '0;
                        row_d      = '0;
                        col_d      = '0;
                        row_base_d = '0;
                        res_y_d    = '0;
                        res_base_d = '0;
                        state_d    = S_FIRST;
                    end
                end
            end

            // FIRST and NEXT share the read walk; FIRST only differs in that it
            // covers three rows before handing over to NEXT.
            S_FIRST, S_NEXT: begin
                sobel_en = 1'b1;
                rd_en    = 1'b1;
                if (col_q == 2'd2) begin
                    col_d      = '0;
                    row_d      = row_q + C_ONE;
                    row_base_d = row_base_q + width_ext;
                    if (row_q == height_q - C_ONE) begin
                        state_d = S_DRAIN;
                    end else if ((state_q == S_FIRST) && (row_q == C_TWO)) begin
                        state_d = S_NEXT;
                    end
                end else begin
                    col_d = col_q + 2'd1;
                end
            end

            S_DRAIN: begin
                sobel_en = 1'b1;
                if (res_y_q == res_target) begin
                    res_y_d    = '0;
                    res_base_d = '0;
                    row_d      = '0;
                    col_d      = '0;
                    row_base_d = '0;
                    gap_d      = 1'b0;
                    if (strip_x_q == width_q - C_THREE) begin
                        state_d = S_DONE;
                    end else begin
                        strip_x_d = strip_x_q + C_ONE;
                        state_d   = S_GAP;
                    end
                end
            end

            // Two cycles with the window controller disabled so it restarts
            // its window fill for the next strip.
            S_GAP: begin
                if (gap_q) begin
                    gap_d   = 1'b0;
                    state_d = S_FIRST;
                end else begin
                    gap_d = 1'b1;
                end
            end

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Pixel path mirrors the RAM latency: strobe follows rd_en by one cycle.
        px_rdy_d  = rd_en;
        px_hold_d = px_rdy_q ? rd_data_i : px_hold_q;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q    <= S_IDLE;
            width_q    <= '0;
            height_q   <= '0;
            strip_x_q  <= '0;
            row_q      <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            res_y_q    <= '0;
            res_base_q <= '0;
            gap_q      <= 1'b0;
            err_q      <= 1'b0;
            px_rdy_q   <= 1'b0;
            px_hold_q  <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            height_q   <= height_d;
            strip_x_q  <= strip_x_d;
            row_q      <= row_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            res_y_q    <= res_y_d;
            res_base_q <= res_base_d;
            gap_q      <= gap_d;
            err_q      <= err_d;
            px_rdy_q   <= px_rdy_d;
            px_hold_q  <= px_hold_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done;
    assign err_cfg_o     = err_q;
    assign rd_en_o       = rd_en;
    assign rd_addr_o     = rd_en ? (row_base_q + strip_x_ext + col_ext) : '0;
    assign start_sobel_o = sobel_en;
    assign px_rdy_o      = px_rdy_q;
    // The RAM data is live in the strobe cycle; otherwise show the last pixel.
    assign px_o          = px_rdy_q ? rd_data_i : px_hold_q;
    assign wr_en_o       = wr_en_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sobel_frame_sequencer
//  Purpose  : Self-checking bench for sobel_frame_sequencer. Provides a pixel
//             RAM model, a behavioural 3x3 Sobel window controller, and a
//             monitor that logs reads, writes, pulses and enable gaps.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sobel_frame_sequencer;

    logic        clk = 1'b0;
    logic        nreset_i = 1'b0;
    logic [7:0]  cfg_width_i = '0;
    logic [7:0]  cfg_height_i = '0;
    logic        start_i = 1'b0;
    logic        busy_o, done_o, err_cfg_o, rd_en_o;
    logic [15:0] rd_addr_o;
    logic [7:0]  rd_data_i = '0;
    logic        start_sobel_o, px_rdy_o;
    logic [7:0]  px_o;
    logic        sobel_rdy_i = 1'b0;
    logic [7:0]  sobel_px_i = '0;
    logic        wr_en_o;
    logic [15:0] wr_addr_o;
    logic [7:0]  wr_data_o;

    always #5 clk = ~clk;

    sobel_frame_sequencer #(
        .PIXEL_WIDTH(8), .DIM_BITS(8), .ADDR_WIDTH(16)
    ) dut (
        .clk_i(clk), .nreset_i(nreset_i),
        .cfg_width_i(cfg_width_i), .cfg_height_i(cfg_height_i), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .err_cfg_o(err_cfg_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .start_sobel_o(start_sobel_o), .px_rdy_o(px_rdy_o), .px_o(px_o),
        .sobel_rdy_i(sobel_rdy_i), .sobel_px_i(sobel_px_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    // ---------------- Sobel magnitude, |Gx|+|Gy| saturated ----------------
    function automatic logic [7:0] sob(input logic [71:0] w);
        int p [9];
        int gx, gy, m;
        for (int i = 0; i < 9; i++) p[i] = int'(w[71-8*i -: 8]);
        gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
        gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        m = gx + gy;
        if (m > 255) m = 255;
        return 8'(m);
    endfunction

    // ---------------- Pixel RAM, 1-cycle latency ----------------
    logic [7:0] mem [0:1023];
    always @(posedge clk) begin
        if (rd_en_o) rd_data_i <= mem[rd_addr_o[9:0]];
    end

    // ---------------- Window controller model ----------------
    // Emits one result per completed row once the first 3x3 window is full.
    logic [71:0] win = '0;
    int unsigned wcnt = 0;
    always @(posedge clk) begin
        if (!start_sobel_o) begin
            wcnt        <= 0;
            sobel_rdy_i <= 1'b0;
        end else if (px_rdy_o) begin
            win         <= {win[63:0], px_o};
            wcnt        <= wcnt + 1;
            sobel_rdy_i <= ((wcnt + 1) >= 9) && (((wcnt + 1) % 3) == 0);
            sobel_px_i  <= sob({win[63:0], px_o});
        end else begin
            sobel_rdy_i <= 1'b0;
        end
    end

    // ---------------- Monitor ----------------
    int unsigned rd_q [$];
    int unsigned wa_q [$];
    int unsigned wd_q [$];
    int unsigned gap_q [$];
    int unsigned done_n = 0, err_n = 0, busy_n = 0, low_run = 0;
    always @(negedge clk) begin
        if (rd_en_o) rd_q.push_back(int'(rd_addr_o));
        if (wr_en_o) begin
            wa_q.push_back(int'(wr_addr_o));
            wd_q.push_back(int'(wr_data_o));
        end
        if (done_o)    done_n <= done_n + 1;
        if (err_cfg_o) err_n  <= err_n + 1;
        if (busy_o)    busy_n <= busy_n + 1;
        if (!busy_o) begin
            low_run <= 0;
        end else if (!start_sobel_o && !done_o) begin
            low_run <= low_run + 1;
        end else if (start_sobel_o && low_run != 0) begin
            gap_q.push_back(low_run);
            low_run <= 0;
        end
    end

    // ---------------- Checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic fill_mem(input int pat);
        for (int a = 0; a < 1024; a++) begin
            case (pat)
                0:       mem[a] = 8'(a);
                1:       mem[a] = 8'd128;
                default: mem[a] = 8'(a * 37 + 11);
            endcase
        end
    endtask

    function automatic logic [7:0] exp_sob(input int w, input int x, input int y);
        logic [71:0] v;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                v[71-8*(3*r+c) -: 8] = mem[(y + r) * w + x + c];
        return sob(v);
    endfunction

    typedef struct {
        int w;
        int h;
        int pat;
        int restart;     // cycle after start at which start_i is re-pulsed (0 = never)
        int exp_err;
        int exp_reads;
        int exp_writes;
        int exp_gaps;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int rb, wb, gb, db, eb, bb, mism, idx, bad;
        fill_mem(v.pat);
        rb = rd_q.size(); wb = wa_q.size(); gb = gap_q.size();
        db = int'(done_n); eb = int'(err_n); bb = int'(busy_n);
        @(posedge clk); #1;
        cfg_width_i = 8'(v.w); cfg_height_i = 8'(v.h); start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (v.restart != 0 && c == v.restart) begin
                cfg_width_i = 8'd3; cfg_height_i = 8'd3; start_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            if (!busy_o && c >= 3) break;
        end
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk($sformatf("busy_end_%0dx%0d", v.w, v.h), int'(busy_o), 0);
        chk($sformatf("err_pulses_%0dx%0d", v.w, v.h), int'(err_n) - eb, v.exp_err);
        chk($sformatf("done_pulses_%0dx%0d", v.w, v.h), int'(done_n) - db, 1 - v.exp_err);
        chk($sformatf("reads_%0dx%0d", v.w, v.h), rd_q.size() - rb, v.exp_reads);
        chk($sformatf("writes_%0dx%0d", v.w, v.h), wa_q.size() - wb, v.exp_writes);
        chk($sformatf("gaps_%0dx%0d", v.w, v.h), gap_q.size() - gb, v.exp_gaps);
        if (v.exp_err != 0) begin
            chk($sformatf("busy_cycles_%0dx%0d", v.w, v.h), int'(busy_n) - bb, 0);
        end else begin
            mism = 0; idx = 0;
            for (int x = 0; x <= v.w - 3; x++)
                for (int r = 0; r < v.h; r++)
                    for (int c = 0; c < 3; c++) begin
                        if (rb + idx >= rd_q.size() || rd_q[rb + idx] != r * v.w + x + c) mism++;
                        idx++;
                    end
            chk($sformatf("read_order_%0dx%0d", v.w, v.h), mism, 0);
            mism = 0; bad = 0; idx = 0;
            for (int x = 0; x <= v.w - 3; x++)
                for (int y = 0; y < v.h - 2; y++) begin
                    if (wb + idx >= wa_q.size()) begin
                        mism++; bad++;
                    end else begin
                        if (wa_q[wb + idx] != y * (v.w - 2) + x) mism++;
                        if (wd_q[wb + idx] != int'(exp_sob(v.w, x, y))) bad++;
                    end
                    idx++;
                end
            chk($sformatf("write_addr_%0dx%0d", v.w, v.h), mism, 0);
            chk($sformatf("write_data_%0dx%0d", v.w, v.h), bad, 0);
            bad = 0;
            for (int g = gb; g < gap_q.size(); g++) if (gap_q[g] != 2) bad++;
            chk($sformatf("gap_len_%0dx%0d", v.w, v.h), bad, 0);
        end
    endtask

    function automatic int outs_or();
        return int'(busy_o | done_o | err_cfg_o | rd_en_o | (|rd_addr_o) | start_sobel_o
                    | px_rdy_o | (|px_o) | wr_en_o | (|wr_addr_o) | (|wr_data_o));
    endfunction

    initial begin
        int rb, wb, db;
        vec_t vecs [8];
        //           W  H  pat rst err reads writes gaps
        vecs[0] = '{3, 3, 0,  0, 0,   9,  1, 0};
        vecs[1] = '{4, 4, 0,  0, 0,  24,  4, 1};
        vecs[2] = '{2, 5, 0,  0, 1,   0,  0, 0};
        vecs[3] = '{5, 6, 2, 30, 0,  54, 12, 2};
        vecs[4] = '{6, 6, 1,  0, 0,  72, 16, 3};
        vecs[5] = '{3, 7, 2,  0, 0,  21,  5, 0};
        vecs[6] = '{5, 3, 0,  0, 0,  27,  3, 2};
        vecs[7] = '{4, 2, 0,  0, 1,   0,  0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", outs_or(), 0);
        #2 nreset_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_after_reset", outs_or(), 0);

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Asynchronous reset while the sequencer is in NEXT.
        fill_mem(0);
        rb = rd_q.size();
        @(posedge clk); #1;
        cfg_width_i = 8'd4; cfg_height_i = 8'd6; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (rd_q.size() - rb >= 11) break;
            @(posedge clk); #1;
        end
        chk("reached_next", int'(rd_q.size() - rb >= 11), 1);
        #2 nreset_i = 1'b0;
        #1;
        chk("abort_outputs", outs_or(), 0);
        repeat (2) @(posedge clk);
        #2 nreset_i = 1'b1;
        rb = rd_q.size(); wb = wa_q.size(); db = int'(done_n);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_reads", rd_q.size() - rb, 0);
        chk("abort_writes", wa_q.size() - wb, 0);
        chk("abort_done", int'(done_n) - db, 0);
        chk("abort_idle", outs_or(), 0);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
